// File: rtl/rtype_reservation_station.sv
// rtl/rtype_reservation_station.sv - R-type reservation station with CDB wakeup and in-order-by-index issue
module rtype_reservation_station #(
   parameter int DEPTH  = 4,
   parameter int OP_W   = 6,
   parameter int TAG_W  = 7,
   parameter int DATA_W = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       dispatch_valid,
   output logic                       dispatch_ready,
   input  logic [OP_W-1:0]            dispatch_op,
   input  logic [TAG_W-1:0]           dispatch_dest_tag,
   input  logic                       dispatch_src1_rdy,
   input  logic [DATA_W-1:0]          dispatch_src1_value,
   input  logic [TAG_W-1:0]           dispatch_src1_tag,
   input  logic                       dispatch_src2_rdy,
   input  logic [DATA_W-1:0]          dispatch_src2_value,
   input  logic [TAG_W-1:0]           dispatch_src2_tag,
   input  logic                       cdb_valid,
   input  logic [TAG_W-1:0]           cdb_tag,
   input  logic [DATA_W-1:0]          cdb_value,
   output logic                       issue_valid,
   input  logic                       issue_ready,
   output logic [OP_W-1:0]            issue_op,
   output logic [DATA_W-1:0]          issue_src1,
   output logic [DATA_W-1:0]          issue_src2,
   output logic [TAG_W-1:0]           issue_dest_tag,
   output logic [$clog2(DEPTH):0]     occupancy
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  s1_rdy;
   logic [DEPTH-1:0]  s2_rdy;
   logic [OP_W-1:0]   op_q   [DEPTH];
   logic [TAG_W-1:0]  dest_q [DEPTH];
   logic [DATA_W-1:0] s1_val [DEPTH];
   logic [DATA_W-1:0] s2_val [DEPTH];
   logic [TAG_W-1:0]  s1_tag [DEPTH];
   logic [TAG_W-1:0]  s2_tag [DEPTH];
   logic [CNT_W-1:0]  count;

   logic [DEPTH-1:0]  ready_vec;
   logic [IDX_W-1:0]  free_idx;
   logic [IDX_W-1:0]  sel_idx;
   logic              any_free;
   logic              any_ready;
   logic              dispatch_fire;
   logic              issue_fire;

   // Downward scan so the last overwrite leaves the lowest matching index.
   always_comb begin
      free_idx = '0;
      sel_idx  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy[i]) free_idx = IDX_W'(i);
         if (ready_vec[i]) sel_idx = IDX_W'(i);
      end
   end

   assign ready_vec = busy & s1_rdy & s2_rdy;
   assign any_free  = |(~busy);
   assign any_ready = |ready_vec;

   // Outputs are forced to their idle values while reset is held.
   assign dispatch_ready = reset | any_free;
   assign issue_valid    = ~reset & any_ready;
   assign occupancy      = reset ? '0 : count;

   assign dispatch_fire = dispatch_valid & any_free & ~reset;
   assign issue_fire    = any_ready & issue_ready & ~reset;

   assign issue_op       = op_q[sel_idx];
   assign issue_src1     = s1_val[sel_idx];
   assign issue_src2     = s2_val[sel_idx];
   assign issue_dest_tag = dest_q[sel_idx];

   always_ff @(posedge clock) begin
      if (reset) begin
         busy  <= '0;
         count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (issue_fire && sel_idx == IDX_W'(i)) begin
               busy[i] <= 1'b0;
            end else if (busy[i]) begin
               if (cdb_valid && !s1_rdy[i] && s1_tag[i] == cdb_tag) begin
                  s1_rdy[i] <= 1'b1;
                  s1_val[i] <= cdb_value;
               end
               if (cdb_valid && !s2_rdy[i] && s2_tag[i] == cdb_tag) begin
                  s2_rdy[i] <= 1'b1;
                  s2_val[i] <= cdb_value;
               end
            end else if (dispatch_fire && free_idx == IDX_W'(i)) begin
               busy[i]   <= 1'b1;
               op_q[i]   <= dispatch_op;
               dest_q[i] <= dispatch_dest_tag;
               s1_tag[i] <= dispatch_src1_tag;
               s2_tag[i] <= dispatch_src2_tag;
               // Same-cycle broadcast of a pending producer is captured here.
               if (!dispatch_src1_rdy && cdb_valid && cdb_tag == dispatch_src1_tag) begin
                  s1_rdy[i] <= 1'b1;
                  s1_val[i] <= cdb_value;
               end else begin
                  s1_rdy[i] <= dispatch_src1_rdy;
                  s1_val[i] <= dispatch_src1_value;
               end
               if (!dispatch_src2_rdy && cdb_valid && cdb_tag == dispatch_src2_tag) begin
                  s2_rdy[i] <= 1'b1;
                  s2_val[i] <= cdb_value;
               end else begin
                  s2_rdy[i] <= dispatch_src2_rdy;
                  s2_val[i] <= dispatch_src2_value;
               end
            end
         end
         case ({dispatch_fire, issue_fire})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_rtype_reservation_station.sv
// tb/tb_rtype_reservation_station.sv - scoreboard bench for rtype_reservation_station
module tb_rtype_reservation_station;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        dispatch_valid = 1'b0;
   logic        dispatch_ready;
   logic [5:0]  dispatch_op = '0;
   logic [6:0]  dispatch_dest_tag = '0;
   logic        dispatch_src1_rdy = 1'b0;
   logic [31:0] dispatch_src1_value = '0;
   logic [6:0]  dispatch_src1_tag = '0;
   logic        dispatch_src2_rdy = 1'b0;
   logic [31:0] dispatch_src2_value = '0;
   logic [6:0]  dispatch_src2_tag = '0;
   logic        cdb_valid = 1'b0;
   logic [6:0]  cdb_tag = '0;
   logic [31:0] cdb_value = '0;
   logic        issue_valid;
   logic        issue_ready = 1'b0;
   logic [5:0]  issue_op;
   logic [31:0] issue_src1;
   logic [31:0] issue_src2;
   logic [6:0]  issue_dest_tag;
   logic [2:0]  occupancy;

   int n_cmp = 0;
   int n_bad = 0;
   logic [76:0] exp_q[$];

   rtype_reservation_station #(.DEPTH(4), .OP_W(6), .TAG_W(7), .DATA_W(32)) dut (
      .clock(clock), .reset(reset),
      .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
      .dispatch_op(dispatch_op), .dispatch_dest_tag(dispatch_dest_tag),
      .dispatch_src1_rdy(dispatch_src1_rdy), .dispatch_src1_value(dispatch_src1_value),
      .dispatch_src1_tag(dispatch_src1_tag),
      .dispatch_src2_rdy(dispatch_src2_rdy), .dispatch_src2_value(dispatch_src2_value),
      .dispatch_src2_tag(dispatch_src2_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
      .issue_src1(issue_src1), .issue_src2(issue_src2),
      .issue_dest_tag(issue_dest_tag), .occupancy(occupancy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Fires at the next rising edge are sampled mid-cycle and matched against the scoreboard.
   always @(negedge clock) begin
      if (!reset && issue_valid && issue_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_issue", 1, 0);
         end else begin
            check("issue_data", {issue_op, issue_dest_tag, issue_src1, issue_src2}, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic dispatch(input logic [5:0] op, input logic [6:0] dest,
                           input logic r1, input logic [31:0] v1, input logic [6:0] t1,
                           input logic r2, input logic [31:0] v2, input logic [6:0] t2);
      dispatch_valid      = 1'b1;
      dispatch_op         = op;
      dispatch_dest_tag   = dest;
      dispatch_src1_rdy   = r1;
      dispatch_src1_value = v1;
      dispatch_src1_tag   = t1;
      dispatch_src2_rdy   = r2;
      dispatch_src2_value = v2;
      dispatch_src2_tag   = t2;
      step();
      dispatch_valid = 1'b0;
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 50) begin
         step();
         cyc++;
      end
      check("drain_timeout", exp_q.size(), 0);
      step();
   endtask

   initial begin
      @(negedge clock);
      check("rst_dispatch_ready", dispatch_ready, 1);
      check("rst_issue_valid", issue_valid, 0);
      check("rst_occupancy", occupancy, 0);
      step();
      reset = 1'b0;
      @(negedge clock);
      check("post_rst_issue_valid", issue_valid, 0);
      check("post_rst_occupancy", occupancy, 0);
      check("post_rst_dispatch_ready", dispatch_ready, 1);

      // ADD with both operands ready
      step();
      issue_ready = 1'b1;
      exp_q.push_back({6'b011011, 7'd5, 32'd7, 32'd3});
      dispatch(6'b011011, 7'd5, 1, 32'd7, 7'd0, 1, 32'd3, 7'd0);
      @(negedge clock);
      check("add_issue_valid", issue_valid, 1);
      step();
      check("add_occupancy", occupancy, 0);

      // SUB waiting on tag 12
      dispatch(6'b011100, 7'd6, 1, 32'h20, 7'd0, 0, 32'hdead, 7'd12);
      @(negedge clock);
      check("sub_wait0", issue_valid, 0);
      step();
      @(negedge clock);
      check("sub_wait1", issue_valid, 0);
      step();
      cdb_valid = 1'b1; cdb_tag = 7'd12; cdb_value = 32'h10;
      exp_q.push_back({6'b011100, 7'd6, 32'h20, 32'h10});
      @(negedge clock);
      check("sub_cdb_cycle", issue_valid, 0);
      step();
      cdb_valid = 1'b0;
      @(negedge clock);
      check("sub_woken", issue_valid, 1);
      drain();

      // Dispatch/CDB bypass on tag 9
      cdb_valid = 1'b1; cdb_tag = 7'd9; cdb_value = 32'hABCD;
      exp_q.push_back({6'b100000, 7'd7, 32'd5, 32'hABCD});
      dispatch(6'b100000, 7'd7, 1, 32'd5, 7'd0, 0, 32'h0, 7'd9);
      cdb_valid = 1'b0;
      @(negedge clock);
      check("bypass_issue_valid", issue_valid, 1);
      drain();

      // Fill to full with the FU stalled
      issue_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({6'(i + 1), 7'(40 + i), 32'(100 + i), 32'(200 + i)});
         dispatch(6'(i + 1), 7'(40 + i), 1, 32'(100 + i), 7'd0, 1, 32'(200 + i), 7'd0);
      end
      @(negedge clock);
      check("full_dispatch_ready", dispatch_ready, 0);
      check("full_occupancy", occupancy, 4);
      dispatch(6'h3f, 7'd99, 1, 32'hbad, 7'd0, 1, 32'hbad, 7'd0);
      @(negedge clock);
      check("full_drop_occupancy", occupancy, 4);
      issue_ready = 1'b1;
      step();
      issue_ready = 1'b0;
      @(negedge clock);
      check("after_one_issue_ready", dispatch_ready, 1);
      check("after_one_issue_occ", occupancy, 3);
      issue_ready = 1'b1;
      drain();
      check("full_drained_occ", occupancy, 0);

      // Two entries woken by one broadcast, issued lowest index first
      issue_ready = 1'b0;
      exp_q.push_back({6'b011011, 7'd50, 32'd100, 32'd1});
      dispatch(6'b011011, 7'd50, 1, 32'd100, 7'd0, 0, 32'd0, 7'd20);
      dispatch(6'b011100, 7'd51, 1, 32'd50, 7'd0, 0, 32'd0, 7'd21);
      exp_q.push_back({6'b100000, 7'd52, 32'd1, 32'd200});
      dispatch(6'b100000, 7'd52, 0, 32'd0, 7'd20, 1, 32'd200, 7'd0);
      cdb_valid = 1'b1; cdb_tag = 7'd20; cdb_value = 32'd1;
      step();
      cdb_valid = 1'b0;
      @(negedge clock);
      check("wake_two_valid", issue_valid, 1);
      check("wake_two_dest", issue_dest_tag, 50);
      issue_ready = 1'b1;
      step();
      @(negedge clock);
      check("wake_two_second", issue_dest_tag, 52);
      step();
      @(negedge clock);
      check("wake_two_idle", issue_valid, 0);
      exp_q.push_back({6'b011100, 7'd51, 32'd50, 32'd2});
      cdb_valid = 1'b1; cdb_tag = 7'd21; cdb_value = 32'd2;
      step();
      cdb_valid = 1'b0;
      drain();

      // Reset mid-operation discards everything
      issue_ready = 1'b0;
      dispatch(6'd1, 7'd60, 1, 32'd1, 7'd0, 1, 32'd1, 7'd0);
      dispatch(6'd2, 7'd61, 0, 32'd0, 7'd30, 1, 32'd1, 7'd0);
      dispatch(6'd3, 7'd62, 1, 32'd1, 7'd0, 0, 32'd0, 7'd31);
      @(negedge clock);
      check("pre_rst_issue_valid", issue_valid, 1);
      check("pre_rst_occupancy", occupancy, 3);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clock);
      check("mid_rst_issue_valid", issue_valid, 0);
      check("mid_rst_occupancy", occupancy, 0);
      check("mid_rst_dispatch_ready", dispatch_ready, 1);
      issue_ready = 1'b1;
      step();
      cdb_valid = 1'b1; cdb_tag = 7'd30; cdb_value = 32'd7;
      step();
      cdb_tag = 7'd31;
      step();
      cdb_valid = 1'b0;
      @(negedge clock);
      check("old_tag_no_issue", issue_valid, 0);
      step();
      step();
      check("final_queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
